// File: rtl/vga_txt_defs_pkg.sv
// vga_txt_defs: shared constants and types for the VGA text-mode scan path.
//   - default 640x480@60 timing (visible / porch / sync widths)
//   - text grid geometry and glyph cell size
//   - bit positions of the char/fg/bg fields in a text RAM word
//   - side_t: per-pixel side-band carried down the fetch pipeline
package vga_txt_defs;

    // Default 640x480 timing, in pixels (H) and lines (V)
    localparam int DEF_H_ACTIVE     = 640;
    localparam int DEF_H_FP         = 16;
    localparam int DEF_H_SYNC       = 96;
    localparam int DEF_H_BP         = 48;
    localparam int DEF_V_ACTIVE     = 480;
    localparam int DEF_V_FP         = 10;
    localparam int DEF_V_SYNC       = 2;
    localparam int DEF_V_BP         = 33;
    localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_BLINK_FRAMES = 32;

    // Text grid
    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    // Counter / address widths
    localparam int HCNT_W = 10;
    localparam int VCNT_W = 10;
    localparam int ADDR_W = 12;

    // Text RAM word layout
    localparam int ATTR_CHAR_LSB = 0;
    localparam int ATTR_CHAR_MSB = 7;
    localparam int ATTR_FG_LSB   = 8;
    localparam int ATTR_FG_MSB   = 11;
    localparam int ATTR_BG_LSB   = 12;
    localparam int ATTR_BG_MSB   = 15;

    // Side-band travelling alongside the memory fetches
    typedef struct packed {
        logic       act;   // pixel inside the visible area
        logic       hs;    // raw hsync (active low)
        logic       vs;    // raw vsync (active low)
        logic       frm;   // pixel (0,0)
        logic       cur;   // cursor forces foreground here
        logic [2:0] xbit;  // pixel column within the glyph
        logic [3:0] grow;  // glyph row
    } side_t;

    // Idle value: syncs deasserted, nothing visible
    localparam side_t SIDE_RST = '{act: 1'b0, hs: 1'b1, vs: 1'b1, frm: 1'b0,
                                   cur: 1'b0, xbit: 3'd0, grow: 4'd0};

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running horizontal/vertical counters and raw timing.
//   i_clk, i_rst        pixel clock, synchronous active-high reset
//   o_hcnt, o_vcnt      current counter values
//   o_hcnt_nxt/_vnxt    values the counters take at the next edge
//   o_hsync, o_vsync    raw syncs (active low), same cycle as counters
//   o_active            counters inside the visible area
//   o_frame_wrap        last pixel of the frame (counters wrap next edge)
module vga_timing
    import vga_txt_defs::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [HCNT_W-1:0] o_hcnt,
    output logic [VCNT_W-1:0] o_vcnt,
    output logic [HCNT_W-1:0] o_hcnt_nxt,
    output logic [VCNT_W-1:0] o_vcnt_nxt,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_active,
    output logic              o_frame_wrap
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_BEG = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] HS_END = HCNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_ACT  = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] VS_BEG = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VS_END = VCNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HCNT_W-1:0] r_hcnt;
    logic [VCNT_W-1:0] r_vcnt;
    logic              w_h_end;
    logic              w_v_end;

    always_comb begin
        w_h_end    = (r_hcnt == H_LAST);
        w_v_end    = (r_vcnt == V_LAST);
        o_hcnt_nxt = w_h_end ? '0 : r_hcnt + 1'b1;
        o_vcnt_nxt = r_vcnt;
        if (w_h_end) begin
            o_vcnt_nxt = w_v_end ? '0 : r_vcnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_hcnt <= o_hcnt_nxt;
            r_vcnt <= o_vcnt_nxt;
        end
    end

    assign o_hcnt       = r_hcnt;
    assign o_vcnt       = r_vcnt;
    assign o_hsync      = !((r_hcnt >= HS_BEG) && (r_hcnt <= HS_END));
    assign o_vsync      = !((r_vcnt >= VS_BEG) && (r_vcnt <= VS_END));
    assign o_active     = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    assign o_frame_wrap = w_h_end && w_v_end;

endmodule

// File: rtl/txt_scan_ctrl.sv
// txt_scan_ctrl: VGA text-mode sequencer.
// Walks the character grid, fetches char/attr words from text RAM and glyph
// rows from font ROM (both 1-cycle synchronous reads), and drives per-pixel
// foreground select and colours with a blinking underline cursor.
//   clk, rst               pixel clock, synchronous active-high reset
//   txt_addr / txt_data    text RAM: row*COLS+col -> {bg, fg, char}
//   font_addr / font_data  font ROM: {char, glyph_row} -> 8 pixels, bit 7 left
//   cursor_en/_x/_y        cursor enable and cell position
//   hsync, vsync           active-low syncs
//   blank                  1 outside the visible area
//   for_en, col_bak, col_for   colour-mapper controls
//   frame_start            one pulse with output pixel (0,0)
// Counter to output latency is 3 cycles for every output.
module txt_scan_ctrl
    import vga_txt_defs::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter int COLS         = vga_txt_defs::COLS,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] txt_addr,
    input  logic [15:0]       txt_data,
    output logic [ADDR_W-1:0] font_addr,
    input  logic [7:0]        font_data,
    input  logic              cursor_en,
    input  logic [6:0]        cursor_x,
    input  logic [4:0]        cursor_y,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              for_en,
    output logic [3:0]        col_bak,
    output logic [3:0]        col_for,
    output logic              frame_start
);

    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [ADDR_W-1:0] COLS_C   = ADDR_W'(COLS);

    // Timing
    logic [HCNT_W-1:0] w_hcnt, w_hcnt_nxt;
    logic [VCNT_W-1:0] w_vcnt, w_vcnt_nxt;
    logic              w_hs, w_vs, w_act, w_frame_wrap;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_hcnt       (w_hcnt),
        .o_vcnt       (w_vcnt),
        .o_hcnt_nxt   (w_hcnt_nxt),
        .o_vcnt_nxt   (w_vcnt_nxt),
        .o_hsync      (w_hs),
        .o_vsync      (w_vs),
        .o_active     (w_act),
        .o_frame_wrap (w_frame_wrap)
    );

    // Blink: phase flips every BLINK_FRAMES frames, starts visible
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_blink_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_frame_wrap) begin
            if (r_blink_cnt == BLK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= !r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // S0: address is registered from the next counter values so that
    // txt_addr lines up with the current counters and the RAM returns data
    // in S1.
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] r_txt_addr;
    logic              w_cur_hit;
    side_t             w_s0;

    always_comb begin
        w_addr_nxt = ADDR_W'(w_vcnt_nxt >> 4) * COLS_C + ADDR_W'(w_hcnt_nxt >> 3);
        // Underline on the last two glyph rows of the cursor cell; the
        // zero-extended compares never match out-of-range cursor values
        // inside the visible area.
        w_cur_hit  = cursor_en && r_blink_phase &&
                     ((w_hcnt >> 3) == HCNT_W'(cursor_x)) &&
                     ((w_vcnt >> 4) == VCNT_W'(cursor_y)) &&
                     (w_vcnt[3:1] == 3'b111);
        w_s0       = SIDE_RST;
        w_s0.act   = w_act;
        w_s0.hs    = w_hs;
        w_s0.vs    = w_vs;
        w_s0.frm   = (w_hcnt == '0) && (w_vcnt == '0);
        w_s0.cur   = w_cur_hit;
        w_s0.xbit  = w_hcnt[2:0];
        w_s0.grow  = w_vcnt[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) r_txt_addr <= '0;
        else     r_txt_addr <= w_addr_nxt;
    end

    assign txt_addr = r_txt_addr;

    // Pipeline valid: memory data is ignored until it reflects a real fetch
    logic [2:1] r_vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) r_vld_pipe <= '0;
        else     r_vld_pipe <= {r_vld_pipe[1], 1'b1};
    end

    // S1: txt_data valid; font address goes straight to the ROM so its data
    // lands in S2.
    side_t r_s1;

    always_ff @(posedge clk) begin
        if (rst) r_s1 <= SIDE_RST;
        else     r_s1 <= w_s0;
    end

    always_comb begin
        font_addr = '0;
        if (r_vld_pipe[1]) begin
            font_addr = {txt_data[ATTR_CHAR_MSB:ATTR_CHAR_LSB], r_s1.grow};
        end
    end

    // S2: font_data valid
    side_t      r_s2;
    logic [3:0] r_fg, r_bg;
    logic       w_pix;
    logic       w_show;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2 <= SIDE_RST;
            r_fg <= '0;
            r_bg <= '0;
        end else begin
            r_s2 <= r_s1;
            r_fg <= r_vld_pipe[1] ? txt_data[ATTR_FG_MSB:ATTR_FG_LSB] : 4'd0;
            r_bg <= r_vld_pipe[1] ? txt_data[ATTR_BG_MSB:ATTR_BG_LSB] : 4'd0;
        end
    end

    assign w_pix  = font_data[3'd7 - r_s2.xbit];
    assign w_show = r_vld_pipe[2] && r_s2.act;

    // S3: registered outputs
    logic       r_hsync, r_vsync, r_blank, r_for_en, r_frame_start;
    logic [3:0] r_col_bak, r_col_for;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_blank       <= 1'b1;
            r_for_en      <= 1'b0;
            r_col_bak     <= '0;
            r_col_for     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= r_s2.hs;
            r_vsync       <= r_s2.vs;
            r_blank       <= !w_show;
            r_frame_start <= r_s2.frm;
            r_for_en      <= w_show && (w_pix || r_s2.cur);
            r_col_bak     <= w_show ? r_bg : 4'd0;
            r_col_for     <= w_show ? r_fg : 4'd0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign blank       = r_blank;
    assign for_en      = r_for_en;
    assign col_bak     = r_col_bak;
    assign col_for     = r_col_for;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_txt_scan_ctrl.sv
// Directed bench. "dut" runs a shrunken geometry (48x38 totals, 4x2 cells,
// 2-frame blink) so whole frames fit in a short run; "dut_def" runs the
// default 640x480 timing for line-level checks. Cycle n counts negedges
// after reset release; the counter value in cycle n is (n%48, n/48%38) for
// dut and (n%800, n/800) for dut_def, outputs show counter n-3.
module tb_txt_scan_ctrl;

    localparam int FRM = 48 * 38;

    logic        clk;
    logic        rst;
    logic [11:0] txt_addr, font_addr;
    logic [15:0] txt_data;
    logic [7:0]  font_data;
    logic        cursor_en;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        hsync, vsync, blank, for_en, frame_start;
    logic [3:0]  col_bak, col_for;

    logic [11:0] d_txt_addr, d_font_addr;
    logic [15:0] d_txt_data;
    logic [7:0]  d_font_data;
    logic        d_cur_en;
    logic [6:0]  d_cur_x;
    logic [4:0]  d_cur_y;
    logic        d_hsync, d_vsync, d_blank, d_for_en, d_frame_start;
    logic [3:0]  d_col_bak, d_col_for;

    logic [15:0] tmem [0:4095];
    logic [7:0]  fmem [0:4095];

    int cyc;
    int n_chk;
    int n_bad;

    txt_scan_ctrl #(
        .H_ACTIVE (32), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (32), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .COLS (4), .BLINK_FRAMES (2)
    ) dut (
        .clk (clk), .rst (rst),
        .txt_addr (txt_addr), .txt_data (txt_data),
        .font_addr (font_addr), .font_data (font_data),
        .cursor_en (cursor_en), .cursor_x (cursor_x), .cursor_y (cursor_y),
        .hsync (hsync), .vsync (vsync), .blank (blank), .for_en (for_en),
        .col_bak (col_bak), .col_for (col_for), .frame_start (frame_start)
    );

    txt_scan_ctrl dut_def (
        .clk (clk), .rst (rst),
        .txt_addr (d_txt_addr), .txt_data (d_txt_data),
        .font_addr (d_font_addr), .font_data (d_font_data),
        .cursor_en (d_cur_en), .cursor_x (d_cur_x), .cursor_y (d_cur_y),
        .hsync (d_hsync), .vsync (d_vsync), .blank (d_blank), .for_en (d_for_en),
        .col_bak (d_col_bak), .col_for (d_col_for), .frame_start (d_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle synchronous memories
    always @(posedge clk) begin
        txt_data  <= tmem[txt_addr];
        font_data <= fmem[font_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_hsync", hsync, 1'b1);
        chk("rst_vsync", vsync, 1'b1);
        chk("rst_blank", blank, 1'b1);
        chk("rst_for_en", for_en, 1'b0);
        chk("rst_col_bak", col_bak, 4'h0);
        chk("rst_col_for", col_for, 4'h0);
        chk("rst_frame_start", frame_start, 1'b0);
        chk("rst_txt_addr", txt_addr, 12'h000);
        chk("rst_font_addr", font_addr, 12'h000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_row;
        int cnt;
        n_chk = 0;
        n_bad = 0;
        cyc   = 0;
        for (int i = 0; i < 4096; i++) begin
            tmem[i] = 16'h0000;
            fmem[i] = 8'h00;
        end
        tmem[6]      = 16'hA541;   // row 1, col 2
        fmem[12'h413] = 8'h81;     // char 0x41, glyph row 3
        d_txt_data = 16'h0000;
        d_font_data = 8'h00;
        d_cur_en = 1'b0;
        d_cur_x  = 7'd0;
        d_cur_y  = 5'd0;
        cursor_en = 1'b1;
        cursor_x  = 7'd3;
        cursor_y  = 5'd1;
        rst = 1'b1;

        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;   // this negedge is cycle 0

        chk("txt_addr_c0", txt_addr, 12'd0);
        goto(2);  chk("fs_early", frame_start, 1'b0);
        goto(3);  chk("fs_first", frame_start, 1'b1);
                  chk("blank_00", blank, 1'b0);
                  chk("for_en_00", for_en, 1'b0);
        goto(4);  chk("fs_once", frame_start, 1'b0);
        goto(8);  chk("txt_addr_col1", txt_addr, 12'd1);
        goto(34); chk("blank_last_act", blank, 1'b0);
        goto(35); chk("blank_h_end", blank, 1'b1);
                  chk("col_bak_h_end", col_bak, 4'h0);
        goto(38); chk("hs_before", hsync, 1'b1);
        goto(39); chk("hs_first_low", hsync, 1'b0);
        goto(46); chk("hs_last_low", hsync, 1'b0);
        goto(47); chk("hs_after", hsync, 1'b1);
        goto(86); chk("hs_l1_before", hsync, 1'b1);
        goto(87); chk("hs_l1_low", hsync, 1'b0);

        goto(639); chk("def_txt_addr_79", d_txt_addr, 12'd79);
        goto(642); chk("def_blank_act", d_blank, 1'b0);
        goto(643); chk("def_blank_end", d_blank, 1'b1);
        goto(658); chk("def_hs_before", d_hsync, 1'b1);
        goto(659); chk("def_hs_low", d_hsync, 1'b0);
        goto(754); chk("def_hs_last", d_hsync, 1'b0);
        goto(755); chk("def_hs_after", d_hsync, 1'b1);
        goto(799); chk("def_txt_addr_99", d_txt_addr, 12'd99);

        // glyph at cell (1,2), line 19 = glyph row 3
        goto(928); chk("txt_addr_cell", txt_addr, 12'd6);
        goto(929); chk("font_addr", font_addr, 12'h413);
        exp_row = 8'b1000_0001;
        for (int i = 0; i < 8; i++) begin
            goto(931 + i);
            chk("glyph_px", for_en, exp_row[7-i]);
            chk("glyph_fg", col_for, 4'h5);
            chk("glyph_bg", col_bak, 4'hA);
            chk("glyph_blank", blank, 1'b0);
        end

        goto(1419); chk("cur_row13", for_en, 1'b0);
        goto(1458); chk("def_hs2_before", d_hsync, 1'b1);
        goto(1459); chk("def_hs2_low", d_hsync, 1'b0);
        goto(1466); chk("cur_left_nb", for_en, 1'b0);
        goto(1467); chk("cur_first", for_en, 1'b1);
        goto(1519); chk("txt_addr_last", txt_addr, 12'd7);
        goto(1522); chk("last_px_blank", blank, 1'b0);
                    chk("last_px_cur", for_en, 1'b1);
        goto(1523); chk("after_last_blank", blank, 1'b1);
                    chk("after_last_for", for_en, 1'b0);
                    chk("after_last_fg", col_for, 4'h0);
        goto(1634); chk("vs_before", vsync, 1'b1);
        goto(1635); chk("vs_first_low", vsync, 1'b0);
        goto(1730); chk("vs_last_low", vsync, 1'b0);
        goto(1731); chk("vs_after", vsync, 1'b1);
        goto(1826); chk("fs_f1_early", frame_start, 1'b0);
        goto(1827); chk("fs_f1", frame_start, 1'b1);
        goto(FRM + 1467); chk("cur_f1_on", for_en, 1'b1);

        // frame 2: cursor hidden, only the glyph's two pixels
        cnt = 0;
        for (int n = 2*FRM + 3; n <= 2*FRM + FRM + 2; n++) begin
            goto(n);
            if (for_en) cnt++;
        end
        chk("f2_for_cnt", cnt, 2);

        // frame 4: cursor visible again, 2 glyph + 16 underline pixels
        cnt = 0;
        for (int n = 4*FRM + 3; n <= 4*FRM + FRM + 2; n++) begin
            goto(n);
            if (for_en) cnt++;
        end
        chk("f4_for_cnt", cnt, 18);

        // frame 5: out-of-range cursor column never forces
        cursor_x = 7'd100;
        cnt = 0;
        for (int n = 5*FRM + 3; n <= 5*FRM + FRM + 2; n++) begin
            goto(n);
            if (for_en) cnt++;
        end
        chk("f5_for_cnt", cnt, 2);

        goto(12800); chk("def_txt_addr_row1", d_txt_addr, 12'd80);
        goto(12808); chk("def_txt_addr_r1c1", d_txt_addr, 12'd81);

        // mid-line reset at counter (17,10)
        goto(7*FRM + 500); chk("pre_rst_blank", blank, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        cyc = 0;
        goto(2);  chk("post_rst_fs_early", frame_start, 1'b0);
        goto(3);  chk("post_rst_fs", frame_start, 1'b1);
        goto(8);  chk("post_rst_txt_addr", txt_addr, 12'd1);
        goto(39); chk("post_rst_hs", hsync, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/txt_scan_ctrl.md
Name: txt_scan_ctrl

Overview:
- Sequencer for the VGA text-mode path: generates 640x480 timing and walks the 80x30 character grid.
- Fetches character/attribute words from text RAM and glyph rows from font ROM, then drives per-pixel for_en/col_bak/col_for into the colour mapper.
- Adds a hardware blinking underline cursor.
- Sits between the text/font memories and the colour mapper; clk is the pixel clock (25 MHz nominal).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- COLS, 80, text columns (H_ACTIVE/8)
- BLINK_FRAMES, 32, frames per cursor blink phase

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- txt_addr  out  12  text RAM word address = row*COLS + col
- txt_data  in  16  text RAM data, 1-cycle sync read: [7:0] char, [11:8] fg colour, [15:12] bg colour
- font_addr  out  12  font ROM address = {char[7:0], glyph_row[3:0]}
- font_data  in  8  font ROM data, 1-cycle sync read; bit 7 = leftmost pixel
- cursor_en  in  1  cursor enable
- cursor_x  in  7  cursor column, 0..79
- cursor_y  in  5  cursor row, 0..29
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank  out  1  1 outside the active area
- for_en  out  1  foreground select to the colour mapper
- col_bak  out  4  background colour index
- col_for  out  4  foreground colour index
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Counters:
  - hcnt 0..H_total-1 (800); vcnt 0..V_total-1 (525). hcnt wraps to 0 and vcnt increments when hcnt = 799; vcnt wraps to 0 when vcnt = 524 at the same time.
  - Active area: hcnt < H_ACTIVE and vcnt < V_ACTIVE.
  - hsync low for hcnt in [656, 751]; vsync low for vcnt in [490, 491].
- Pipeline (stage k = k cycles after the counter value):
  - S0: txt_addr = (vcnt>>4)*COLS + (hcnt>>3), registered. Issued every pixel, including in blanking.
  - S1: txt_data valid; register font_addr = {char, vcnt[3:0]}; delay fg, bg, hcnt[2:0], active flag, cursor-hit flag and syncs.
  - S2: font_data valid; pixel = font_data[7 - xbit].
  - S3: outputs registered.
  - Total latency counter → hsync/vsync/blank/colour outputs is exactly 3 cycles. All sync/blank signals are delayed by the same 3 stages so they stay aligned with pixel data.
- Output rules (S3):
  - When not active: blank=1, for_en=0, col_bak=0, col_for=0.
  - When active: blank=0, col_bak=bg, col_for=fg, for_en = pixel OR cursor_force.
  - cursor_force = cursor_en AND blink_phase AND (cell col = cursor_x) AND (cell row = cursor_y) AND glyph_row in {14, 15}.
  - cursor_x/y are sampled at S0; out-of-range values never match and are not an error.
- Blink: a frame counter increments at vcnt wrap. blink_phase toggles when the counter reaches BLINK_FRAMES-1, and the counter returns to 0. blink_phase resets to 1 (cursor visible).
- frame_start: 1 for exactly one cycle, when the S3 output corresponds to hcnt=0, vcnt=0.
- Reset: hcnt=vcnt=0, frame counter 0, pipeline flushed.
  - Outputs: hsync=1, vsync=1, blank=1, for_en=0, col_bak=0, col_for=0, frame_start=0, txt_addr=0, font_addr=0.
  - Reset asserted mid-frame takes effect on the next edge. The first frame_start after deassertion occurs 3 cycles after the first counted cycle.
- Memory data is never used while the pipeline is invalid after reset; the active flag is 0 through the flush.

Decomposition:
- Shared package/include `vga_txt_defs`: the timing constants (H_*, V_*, totals), COLS=80, ROWS=30, GLYPH_W=8, GLYPH_H=16, attribute bit-field positions.
- One sub-module, `vga_timing`: hcnt/vcnt counters, raw hsync/vsync/active, frame-wrap strobe.
- The fetch pipeline and cursor/blink logic stay in `txt_scan_ctrl`.

Test Plan:
- Reset, then free-run 2 frames → hsync period 800 cycles with low width 96; vsync low for exactly 2 lines (1600 cycles); frame_start period 420000 cycles.
- Text RAM model with cell (row 1, col 2) = 0xA541, font row 3 of char 0x41 = 0x81 → at output for (hcnt 16..23, vcnt 19): for_en = 1,0,0,0,0,0,0,1; col_for=5; col_bak=A; blank=0.
- Counter at hcnt=639, vcnt=479 → txt_addr=2399; output 3 cycles later is the last active pixel; the next output has blank=1 and all colour outputs 0.
- cursor_en=1, cursor at (79,29), all-zero glyphs → for_en=1 on vcnt 478..479, hcnt 632..639 during visible phase. After 32 frames for_en=0 there; after 64 frames it is 1 again.
- Assert rst for 1 cycle mid-line (hcnt≈300, vcnt≈200) → next cycle all outputs at reset values; counters restart; frame_start appears 3 cycles after rst deasserts.
- cursor_x=100 with cursor_en=1 → no for_en forcing anywhere over a full frame.
